difficulty_ctrl: RTL

DIFFICULTY_CTRL -- requirements
Module: difficulty_ctrl

---
 rtl/difficulty_pkg.sv | 24 ++
 rtl/difficulty_ctrl_button_cond.sv | 102 ++++++++++
 rtl/difficulty_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/difficulty_pkg.sv
// difficulty_pkg: shared definitions for the difficulty level selector.
//   DEFAULT_NUM_LEVELS - default number of selectable levels
//   step_dir_e         - resolved step direction for one cycle
//   level_width()      - width of the level register for a level count
//   cnt_width()        - width of a counter that must hold the value n
package difficulty_pkg;

    localparam int DEFAULT_NUM_LEVELS = 4;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DOWN = 2'd2
    } step_dir_e;

    function automatic int level_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/difficulty_ctrl_button_cond.sv
// button_cond: conditions one raw push button into a one-cycle step pulse.
// Optional feature macro: DIFFICULTY_DEBOUNCE_EN (adds a stable-time filter
// in front of the edge detector).
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   btn         - raw button input, active high
//   hold_other  - the other button's conditioned level; blocks auto-repeat
//   held        - conditioned (sampled/filtered) button level
//   step        - one-cycle step request (rising edge or auto-repeat)
module button_cond
    import difficulty_pkg::*;
#(
    parameter int REPEAT_CYCLES = 0
`ifdef DIFFICULTY_DEBOUNCE_EN
    , parameter int DEBOUNCE_CYCLES = 16
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic hold_other,
    output logic held,
    output logic step
);

    localparam int RW = cnt_width(REPEAT_CYCLES);

    logic          s_q, s_d;
    logic          p_q;
    logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic          edge_req, rpt_req;

`ifdef DIFFICULTY_DEBOUNCE_EN
    localparam int DW = cnt_width(DEBOUNCE_CYCLES);

    logic [DW-1:0] db_cnt_q, db_cnt_d;

    // The filtered value only follows the raw input once it has disagreed
    // for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    always_comb begin
        s_d      = s_q;
        db_cnt_d = '0;
        if (btn != s_q) begin
            if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                s_d = btn;
            end else begin
                db_cnt_d = db_cnt_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            db_cnt_q <= '0;
        end else begin
            db_cnt_q <= db_cnt_d;
        end
    end
`else
    always_comb begin
        s_d = btn;
    end
`endif

    // rpt_cnt_q == 0 means no repeat is armed. The edge step arms it at 1, so
    // the count equals the number of cycles since the last step; reaching
    // REPEAT_CYCLES fires a repeat. The period keeps running while the other
    // button is held, only the pulse itself is suppressed.
    always_comb begin
        edge_req  = s_q & ~p_q;
        rpt_cnt_d = '0;
        rpt_req   = 1'b0;
        if (REPEAT_CYCLES > 0) begin
            if (edge_req) begin
                rpt_cnt_d = RW'(1);
            end else if (s_q && (rpt_cnt_q != '0)) begin
                if (rpt_cnt_q == RW'(REPEAT_CYCLES)) begin
                    rpt_cnt_d = RW'(1);
                    rpt_req   = ~hold_other;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + RW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_q       <= 1'b0;
            p_q       <= 1'b0;
            rpt_cnt_q <= '0;
        end else begin
            s_q       <= s_d;
            p_q       <= s_q;
            rpt_cnt_q <= rpt_cnt_d;
        end
    end

    assign held = s_q;
    assign step = edge_req | rpt_req;

endmodule

// File: rtl/difficulty_ctrl.sv
// difficulty_ctrl: up/down level selector driven by two push buttons.
// Optional feature macro: DIFFICULTY_DEBOUNCE_EN (debounce filter per button;
// DEBOUNCE_CYCLES is only meaningful when it is defined).
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   increment   - raw "up" button, active high
//   decrement   - raw "down" button, active high
//   level       - current level, 0..NUM_LEVELS-1
//   changed     - one-cycle pulse in the cycle after level changed
//   at_min      - level == 0
//   at_max      - level == NUM_LEVELS-1
module difficulty_ctrl
    import difficulty_pkg::*;
#(
    parameter int  NUM_LEVELS      = DEFAULT_NUM_LEVELS,
    parameter int  WRAP            = 1,
    parameter int  REPEAT_CYCLES   = 0,
    parameter int  DEBOUNCE_CYCLES = 16,
    localparam int LW              = level_width(NUM_LEVELS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          increment,
    input  logic          decrement,
    output logic [LW-1:0] level,
    output logic          changed,
    output logic          at_min,
    output logic          at_max
);

    if (NUM_LEVELS < 2 || NUM_LEVELS > 256 || REPEAT_CYCLES < 0 ||
        DEBOUNCE_CYCLES < 1) begin : g_bad_params
        $error("difficulty_ctrl: parameter out of legal range");
    end

    localparam logic [LW-1:0] MAX_LEVEL = LW'(NUM_LEVELS - 1);

    logic      inc_held, dec_held;
    logic      inc_step, dec_step;
    step_dir_e dir;

    logic [LW-1:0] level_q, level_d;
    logic          changed_q, changed_d;

    button_cond #(
        .REPEAT_CYCLES   (REPEAT_CYCLES)
`ifdef DIFFICULTY_DEBOUNCE_EN
        , .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`endif
    ) u_inc (
        .clk        (clk),
        .reset      (reset),
        .btn        (increment),
        .hold_other (dec_held),
        .held       (inc_held),
        .step       (inc_step)
    );

    button_cond #(
        .REPEAT_CYCLES   (REPEAT_CYCLES)
`ifdef DIFFICULTY_DEBOUNCE_EN
        , .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`endif
    ) u_dec (
        .clk        (clk),
        .reset      (reset),
        .btn        (decrement),
        .hold_other (inc_held),
        .held       (dec_held),
        .step       (dec_step)
    );

    // Simultaneous up and down requests cancel. Comparing against MAX_LEVEL
    // (not the register's natural wrap) keeps non-power-of-two counts in range.
    always_comb begin
        dir = STEP_NONE;
        if (inc_step && !dec_step) begin
            dir = STEP_UP;
        end else if (dec_step && !inc_step) begin
            dir = STEP_DOWN;
        end

        level_d = level_q;
        case (dir)
            STEP_UP: begin
                if (level_q == MAX_LEVEL) begin
                    if (WRAP != 0) level_d = '0;
                end else begin
                    level_d = level_q + LW'(1);
                end
            end
            STEP_DOWN: begin
                if (level_q == '0) begin
                    if (WRAP != 0) level_d = MAX_LEVEL;
                end else begin
                    level_d = level_q - LW'(1);
                end
            end
            default: ;
        endcase

        changed_d = (level_d != level_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q   <= '0;
            changed_q <= 1'b0;
        end else begin
            level_q   <= level_d;
            changed_q <= changed_d;
        end
    end

    assign level   = level_q;
    assign changed = changed_q;
    assign at_min  = (level_q == '0);
    assign at_max  = (level_q == MAX_LEVEL);

endmodule
